// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures words from a UART receiver via a rcvd/rxack handshake into a first-word fall-through FIFO.
//   Parameters: DATA_WIDTH (word width), ADDR_WIDTH (depth = 2**ADDR_WIDTH).
//   Ports: clk, reset (async active-low);
//          receiver side: rcvd, datarx, rx_err in, rxack out (one-cycle pulse);
//          consumer side: dout, dvalid out, dready in (pop when dvalid & dready);
//          status: count (occupancy), full, err_cnt (saturating errored-word count).
//   Build option: UART_RX_FIFO_DROP_ERR_EN drops words received with rx_err=1
//   (still acknowledged and counted, even when full); undefined stores them normally.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rcvd,
  input  logic [DATA_WIDTH-1:0] datarx,
  input  logic                  rx_err,
  output logic                  rxack,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dvalid,
  input  logic                  dready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic [7:0]            err_cnt
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACK      = 2'd1;
  localparam logic [1:0] WAIT_LOW = 2'd2;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
  logic [1:0]            r_state;
  logic [1:0]            w_state_nx;
  logic [ADDR_WIDTH:0]   r_wr;
  logic [ADDR_WIDTH:0]   r_rd;
  logic [7:0]            r_err_cnt;
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic                  w_take;
  logic                  w_wr;
  logic                  w_pop;
  // Extra pointer MSB distinguishes full (MSBs differ) from empty (all equal).
  assign full    = (r_wr[ADDR_WIDTH] != r_rd[ADDR_WIDTH]) && (r_wr[ADDR_WIDTH-1:0] == r_rd[ADDR_WIDTH-1:0]);
  assign dvalid  = r_wr != r_rd;
  assign count   = r_wr - r_rd;
  assign dout    = r_mem[r_rd[ADDR_WIDTH-1:0]];
  assign w_pop   = dvalid & dready;
  assign rxack   = r_state == ACK;
  assign err_cnt = r_err_cnt;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  // Errored words are never stored, so they need no free slot to be acknowledged.
  assign w_take = (r_state == IDLE) & rcvd & (rx_err | ~full);
  assign w_wr   = w_take & ~rx_err;
`else
  assign w_take = (r_state == IDLE) & rcvd & ~full;
  assign w_wr   = w_take;
`endif
  // WAIT_LOW blocks recapture until the receiver drops rcvd after the ack.
  always_comb
    w_state_nx = r_state == IDLE     ? (w_take ? ACK : IDLE) :
                 r_state == ACK      ? WAIT_LOW :
                 r_state == WAIT_LOW ? (rcvd ? WAIT_LOW : IDLE) : IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_wr) r_wr <= r_wr + PTR_ONE;
      if (w_pop) r_rd <= r_rd + PTR_ONE;
      if (w_take && rx_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr[ADDR_WIDTH-1:0]] <= datarx;
endmodule
